neck_gate_ctrl: RTL and testbench

Output stage of the neck-detection chain: consumes the per-sample neck verdict from the judge stage and drives the welder IGBT gate. A detected neck cuts power for a fixed off-time, followed by a blanking interval during which detections are ignored while the arc re-establishes. A rate monitor latches a fail-safe fault if cuts arrive too often. Sits between the neck judge and the `power_switch` pin in the 100 MHz domain.

---
 rtl/neck_pkg.sv | 23 ++
 rtl/neck_rate_monitor.sv | 45 ++++
 rtl/neck_gate_ctrl.sv | 168 ++++++++++++++++
 tb/tb_neck_gate_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neck_pkg.sv
// Shared types and helpers for the neck-detection gate controller.
// Holds the gate state encoding and the cut-counter width.
package neck_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        CUT   = 2'd1,
        BLANK = 2'd2,
        FAULT = 2'd3
    } gate_state_t;

    localparam int CUT_CNT_W = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Saturating increment: the total-cuts counter sticks at all-ones.
    function automatic logic [CUT_CNT_W-1:0] sat_inc(input logic [CUT_CNT_W-1:0] v);
        return (v == {CUT_CNT_W{1'b1}}) ? v : v + CUT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/neck_rate_monitor.sv
// Cut-rate monitor: free-running window counter plus the number of accepted
// detections in the current window; flags the detection that reaches the limit.
module neck_rate_monitor
    import neck_pkg::*;
#(
    parameter int WINDOW_CYCLES = 10000000,
    parameter int FAULT_CUTS    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic accept,
    output logic rate_trip
);

    localparam int WIN_W = $clog2(WINDOW_CYCLES);
    localparam int CNT_W = $clog2(FAULT_CUTS + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRIP_CNT = CNT_W'(FAULT_CUTS);

    logic [WIN_W-1:0] win_cnt_r;
    logic [CNT_W-1:0] cuts_r;
    logic [CNT_W-1:0] cuts_base_s;
    logic [CNT_W-1:0] cuts_next_s;
    logic             wrap_s;

    // A detection in the wrap cycle is counted against the fresh window.
    always_comb begin
        wrap_s      = (win_cnt_r == WIN_LAST);
        cuts_base_s = wrap_s ? {CNT_W{1'b0}} : cuts_r;
        cuts_next_s = cuts_base_s + CNT_W'(1);
        rate_trip   = accept & (cuts_next_s == TRIP_CNT);
    end

    // Window counter and per-window cut count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt_r <= {WIN_W{1'b0}};
            cuts_r    <= {CNT_W{1'b0}};
        end else begin
            win_cnt_r <= wrap_s ? {WIN_W{1'b0}} : win_cnt_r + WIN_W'(1);
            cuts_r    <= accept ? cuts_next_s : cuts_base_s;
        end
    end

endmodule

// File: rtl/neck_gate_ctrl.sv
// IGBT gate controller: cuts welder power for a fixed off-time on each neck
// verdict, blanks further verdicts afterwards, and latches a rate fault.
module neck_gate_ctrl
    import neck_pkg::*;
#(
    parameter int OFF_CYCLES    = 20000,
    parameter int BLANK_CYCLES  = 50000,
    parameter int WINDOW_CYCLES = 10000000,
    parameter int FAULT_CUTS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 neck_valid,
    input  logic                 neck_flag,
    input  logic                 ctl_switch,
    output logic                 power_switch,
    output logic                 busy,
    output logic                 fault,
    output logic [CUT_CNT_W-1:0] cut_cnt
);

    localparam int TMR_MAX = max_int(OFF_CYCLES, BLANK_CYCLES);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] OFF_LOAD   = TMR_W'(OFF_CYCLES - 1);
    localparam logic [TMR_W-1:0] BLANK_LOAD = TMR_W'(BLANK_CYCLES - 1);

    gate_state_t          state_r;
    gate_state_t          next_state_s;
    logic [TMR_W-1:0]     timer_r;
    logic [TMR_W-1:0]     timer_next_s;
    logic [CUT_CNT_W-1:0] cut_cnt_r;
    logic [CUT_CNT_W-1:0] cut_cnt_next_s;
    logic                 detect_s;
    logic                 accept_s;
    logic                 rate_trip_s;
    logic                 power_s;
    logic                 busy_s;
    logic                 fault_s;
    logic                 power_switch_r;
    logic                 busy_r;
    logic                 fault_r;

    assign detect_s = ctl_switch & neck_valid & neck_flag;
    assign accept_s = (state_r == RUN) & detect_s;

    neck_rate_monitor #(
        .WINDOW_CYCLES (WINDOW_CYCLES),
        .FAULT_CUTS    (FAULT_CUTS)
    ) u_rate (
        .clk       (clk),
        .rst       (rst),
        .accept    (accept_s),
        .rate_trip (rate_trip_s)
    );

    // State, timer and total-cut counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= RUN;
            timer_r   <= {TMR_W{1'b0}};
            cut_cnt_r <= {CUT_CNT_W{1'b0}};
        end else begin
            state_r   <= next_state_s;
            timer_r   <= timer_next_s;
            cut_cnt_r <= cut_cnt_next_s;
        end
    end

    // Next-state logic; a bypass request beats timer expiry in CUT and BLANK.
    always_comb begin
        next_state_s   = state_r;
        timer_next_s   = timer_r;
        cut_cnt_next_s = cut_cnt_r;
        case (state_r)
            RUN: begin
                if (accept_s) begin
                    if (rate_trip_s) begin
                        next_state_s = FAULT;
                    end else begin
                        next_state_s   = CUT;
                        timer_next_s   = OFF_LOAD;
                        cut_cnt_next_s = sat_inc(cut_cnt_r);
                    end
                end else begin
                    next_state_s = RUN;
                end
            end
            CUT: begin
                if (!ctl_switch) begin
                    next_state_s = RUN;
                end else if (timer_r == {TMR_W{1'b0}}) begin
                    next_state_s = BLANK;
                    timer_next_s = BLANK_LOAD;
                end else begin
                    timer_next_s = timer_r - TMR_W'(1);
                end
            end
            BLANK: begin
                if (!ctl_switch) begin
                    next_state_s = RUN;
                end else if (timer_r == {TMR_W{1'b0}}) begin
                    next_state_s = RUN;
                end else begin
                    timer_next_s = timer_r - TMR_W'(1);
                end
            end
            FAULT: begin
                next_state_s = FAULT;
            end
            default: begin
                next_state_s = FAULT;
            end
        endcase
    end

    // Output decode from the upcoming state so registered outputs align with it.
    always_comb begin
        power_s = 1'b1;
        busy_s  = 1'b0;
        fault_s = 1'b0;
        case (next_state_s)
            RUN: begin
                power_s = 1'b1;
                busy_s  = 1'b0;
                fault_s = 1'b0;
            end
            CUT: begin
                power_s = 1'b0;
                busy_s  = 1'b1;
                fault_s = 1'b0;
            end
            BLANK: begin
                power_s = 1'b1;
                busy_s  = 1'b1;
                fault_s = 1'b0;
            end
            FAULT: begin
                power_s = 1'b1;
                busy_s  = 1'b0;
                fault_s = 1'b1;
            end
            default: begin
                power_s = 1'b1;
                busy_s  = 1'b0;
                fault_s = 1'b1;
            end
        endcase
    end

    // Output registers; reset leaves the IGBT conducting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            power_switch_r <= 1'b1;
            busy_r         <= 1'b0;
            fault_r        <= 1'b0;
        end else begin
            power_switch_r <= power_s;
            busy_r         <= busy_s;
            fault_r        <= fault_s;
        end
    end

    assign power_switch = power_switch_r;
    assign busy         = busy_r;
    assign fault        = fault_r;
    assign cut_cnt      = cut_cnt_r;

endmodule

// File: tb/tb_neck_gate_ctrl.sv
// Directed bench for neck_gate_ctrl: expected per-cycle outputs are queued as
// each step is set up and compared as the cycles elapse.
module tb_neck_gate_ctrl;

    logic        clk;
    logic        rst;
    logic        neck_valid;
    logic        neck_flag;
    logic        ctl_switch;
    logic        power_switch;
    logic        busy;
    logic        fault;
    logic [15:0] cut_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        string       tag;
        int          cyc;
        logic        ps;
        logic        bz;
        logic        ft;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    neck_gate_ctrl #(
        .OFF_CYCLES    (4),
        .BLANK_CYCLES  (6),
        .WINDOW_CYCLES (100),
        .FAULT_CUTS    (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .neck_valid   (neck_valid),
        .neck_flag    (neck_flag),
        .ctl_switch   (ctl_switch),
        .power_switch (power_switch),
        .busy         (busy),
        .fault        (fault),
        .cut_cnt      (cut_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic expect_rng(input string tag, input int from, input int to,
                              input logic ps, input logic bz, input logic ft,
                              input logic [15:0] cnt);
        exp_t e;
        for (int c = from; c <= to; c++) begin
            e.tag = tag;
            e.cyc = c;
            e.ps  = ps;
            e.bz  = bz;
            e.ft  = ft;
            e.cnt = cnt;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk({e.tag, "_cycle"}, 32'(e.cyc), 32'(cyc));
            chk({e.tag, "_power_switch"}, 32'(power_switch), 32'(e.ps));
            chk({e.tag, "_busy"}, 32'(busy), 32'(e.bz));
            chk({e.tag, "_fault"}, 32'(fault), 32'(e.ft));
            chk({e.tag, "_cut_cnt"}, 32'(cut_cnt), 32'(e.cnt));
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        drain();
    endtask

    task automatic idle_to(input int k);
        while (cyc < k) next_cycle();
    endtask

    task automatic strobe(input logic flag);
        neck_valid = 1'b1;
        neck_flag  = flag;
        next_cycle();
        neck_valid = 1'b0;
        neck_flag  = 1'b0;
    endtask

    // Cycle 0 is the first cycle after release; the window counter equals cyc mod 100.
    task automatic do_reset();
        rst        = 1'b1;
        neck_valid = 1'b0;
        neck_flag  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        drain();
    endtask

    task automatic end_test(input string tag);
        chk({tag, "_scoreboard_empty"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        rst        = 1'b1;
        neck_valid = 1'b0;
        neck_flag  = 1'b0;
        ctl_switch = 1'b1;

        // Single cut: detection at 10
        expect_rng("t1_reset", 0, 0, 1'b1, 1'b0, 1'b0, 16'd0);
        do_reset();
        expect_rng("t1_idle", 1, 10, 1'b1, 1'b0, 1'b0, 16'd0);
        expect_rng("t1_cut", 11, 14, 1'b0, 1'b1, 1'b0, 16'd1);
        expect_rng("t1_blank", 15, 20, 1'b1, 1'b1, 1'b0, 16'd1);
        expect_rng("t1_run", 21, 21, 1'b1, 1'b0, 1'b0, 16'd1);
        idle_to(10);
        strobe(1'b1);
        idle_to(21);
        end_test("t1");

        // Blanking: flag=0 strobe at 5, cut at 10, strobes at 16/20 ignored, 21 honoured
        expect_rng("t2_reset", 0, 0, 1'b1, 1'b0, 1'b0, 16'd0);
        do_reset();
        expect_rng("t2_idle", 1, 10, 1'b1, 1'b0, 1'b0, 16'd0);
        expect_rng("t2_cut", 11, 14, 1'b0, 1'b1, 1'b0, 16'd1);
        expect_rng("t2_blank", 15, 20, 1'b1, 1'b1, 1'b0, 16'd1);
        expect_rng("t2_run", 21, 21, 1'b1, 1'b0, 1'b0, 16'd1);
        expect_rng("t2_cut2", 22, 25, 1'b0, 1'b1, 1'b0, 16'd2);
        expect_rng("t2_blank2", 26, 26, 1'b1, 1'b1, 1'b0, 16'd2);
        idle_to(5);
        strobe(1'b0);
        idle_to(10);
        strobe(1'b1);
        idle_to(16);
        strobe(1'b1);
        idle_to(20);
        strobe(1'b1);
        strobe(1'b1);
        idle_to(26);
        end_test("t2");

        // Bypass, then abort of a cut at cycle 12
        ctl_switch = 1'b0;
        expect_rng("t3_reset", 0, 0, 1'b1, 1'b0, 1'b0, 16'd0);
        do_reset();
        expect_rng("t3_bypass", 1, 10, 1'b1, 1'b0, 1'b0, 16'd0);
        expect_rng("t3_cut", 11, 12, 1'b0, 1'b1, 1'b0, 16'd1);
        expect_rng("t3_abort", 13, 16, 1'b1, 1'b0, 1'b0, 16'd1);
        expect_rng("t3_recut", 17, 17, 1'b0, 1'b1, 1'b0, 16'd2);
        idle_to(5);
        strobe(1'b1);
        idle_to(8);
        strobe(1'b1);
        idle_to(10);
        ctl_switch = 1'b1;
        strobe(1'b1);
        next_cycle();
        ctl_switch = 1'b0;
        next_cycle();
        idle_to(14);
        strobe(1'b1);
        idle_to(16);
        ctl_switch = 1'b1;
        strobe(1'b1);
        end_test("t3");

        // Rate fault: detections at 5, 20, 40 in one window
        expect_rng("t4_reset", 0, 0, 1'b1, 1'b0, 1'b0, 16'd0);
        do_reset();
        expect_rng("t4_idle", 1, 5, 1'b1, 1'b0, 1'b0, 16'd0);
        expect_rng("t4_cut1", 6, 9, 1'b0, 1'b1, 1'b0, 16'd1);
        expect_rng("t4_blank1", 10, 15, 1'b1, 1'b1, 1'b0, 16'd1);
        expect_rng("t4_run1", 16, 20, 1'b1, 1'b0, 1'b0, 16'd1);
        expect_rng("t4_cut2", 21, 24, 1'b0, 1'b1, 1'b0, 16'd2);
        expect_rng("t4_blank2", 25, 30, 1'b1, 1'b1, 1'b0, 16'd2);
        expect_rng("t4_run2", 31, 40, 1'b1, 1'b0, 1'b0, 16'd2);
        expect_rng("t4_fault", 41, 60, 1'b1, 1'b0, 1'b1, 16'd2);
        idle_to(5);
        strobe(1'b1);
        idle_to(20);
        strobe(1'b1);
        idle_to(40);
        strobe(1'b1);
        idle_to(50);
        strobe(1'b1);
        idle_to(60);
        end_test("t4");

        // Window wrap: third detection lands in the wrap cycle (counter 99)
        expect_rng("t5_reset", 0, 0, 1'b1, 1'b0, 1'b0, 16'd0);
        do_reset();
        expect_rng("t5_idle", 1, 5, 1'b1, 1'b0, 1'b0, 16'd0);
        expect_rng("t5_cut1", 6, 9, 1'b0, 1'b1, 1'b0, 16'd1);
        expect_rng("t5_blank1", 10, 15, 1'b1, 1'b1, 1'b0, 16'd1);
        expect_rng("t5_run1", 16, 20, 1'b1, 1'b0, 1'b0, 16'd1);
        expect_rng("t5_cut2", 21, 24, 1'b0, 1'b1, 1'b0, 16'd2);
        expect_rng("t5_blank2", 25, 30, 1'b1, 1'b1, 1'b0, 16'd2);
        expect_rng("t5_run2", 31, 99, 1'b1, 1'b0, 1'b0, 16'd2);
        expect_rng("t5_wrapcut", 100, 103, 1'b0, 1'b1, 1'b0, 16'd3);
        expect_rng("t5_blank3", 104, 109, 1'b1, 1'b1, 1'b0, 16'd3);
        expect_rng("t5_run3", 110, 120, 1'b1, 1'b0, 1'b0, 16'd3);
        expect_rng("t5_cut4", 121, 124, 1'b0, 1'b1, 1'b0, 16'd4);
        expect_rng("t5_blank4", 125, 130, 1'b1, 1'b1, 1'b0, 16'd4);
        expect_rng("t5_run4", 131, 140, 1'b1, 1'b0, 1'b0, 16'd4);
        expect_rng("t5_fault", 141, 145, 1'b1, 1'b0, 1'b1, 16'd4);
        idle_to(5);
        strobe(1'b1);
        idle_to(20);
        strobe(1'b1);
        idle_to(99);
        strobe(1'b1);
        idle_to(120);
        strobe(1'b1);
        idle_to(140);
        strobe(1'b1);
        idle_to(145);
        end_test("t5");

        // Asynchronous reset in the middle of a cut
        expect_rng("t6_reset", 0, 0, 1'b1, 1'b0, 1'b0, 16'd0);
        do_reset();
        expect_rng("t6_idle", 1, 10, 1'b1, 1'b0, 1'b0, 16'd0);
        expect_rng("t6_cut", 11, 12, 1'b0, 1'b1, 1'b0, 16'd1);
        idle_to(10);
        strobe(1'b1);
        idle_to(12);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_power_switch", 32'(power_switch), 32'd1);
        chk("t6_async_cut_cnt", 32'(cut_cnt), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_fault", 32'(fault), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        end_test("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
